rc5_key_expand: RTL

RC5-16/r/16 key-expansion unit. It takes the 128-bit user key and a round count, and builds the expanded round-key table S[0..2r+1] of 16-bit words. The cipher datapath reads the table through a synchronous read port. The block writes the table once per key; the round engine is its only reader. Each 32-bit data block is two 16-bit halves A and B.

---
 rtl/rc5_key_expand.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rc5_key_expand.sv
// rc5_key_expand
// ---------------------------------------------------------------------------
// RC5-16/r/16 key-expansion unit. Takes a 128-bit user key and a round count
// r (0..15) and builds the expanded round-key table S[0..2r+1] of 16-bit
// words. The round engine reads the table through a registered read port.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       request expansion (accepted only while idle)
//   num_rounds  round count r, latched with start
//   key         128-bit user key, latched with start; L[j] = key[16j+15:16j]
//   busy        high while the table is being initialised or mixed
//   done        one-cycle pulse when the table is complete
//   ready       level, table valid; cleared by an accepted start or rst
//   rd_addr     table index for the read port
//   rd_data     registered read data (0 when the table is not valid or the
//               index is beyond the table)
// ---------------------------------------------------------------------------
module rc5_key_expand #(
  parameter logic [15:0] P_CONST = 16'hB7E1,
  parameter logic [15:0] Q_CONST = 16'h9E37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   num_rounds,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         ready,
  input  logic [4:0]   rd_addr,
  output logic [15:0]  rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // 16-bit rotate left by 0..15; a shift of 16 yields zero, so s=0 is identity.
  function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] s);
    rotl16 = (x << s) | (x >> (5'd16 - {1'b0, s}));
  endfunction

  state_t      state_r;
  logic        busy_r;
  logic        done_r;
  logic        ready_r;
  logic [15:0] rd_data_r;

  logic [15:0] s_mem [32];
  logic [15:0] l_mem [8];

  logic [15:0] acc_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [4:0]  i_r;
  logic [2:0]  j_r;
  logic [6:0]  count_r;
  logic [5:0]  t_r;
  logic [6:0]  n_r;

  logic [5:0]  t_s;
  logic [6:0]  n_s;
  logic [5:0]  i_inc_s;
  logic [15:0] sum_a_s;
  logic [15:0] a_next_s;
  logic [15:0] ab_s;
  logic [15:0] b_next_s;

  // Table size and mix iteration count from the requested round count:
  // t = 2r+2, n = 3*max(t,8) which is 24 for r<=3 and 6r+6 above that.
  always_comb begin
    t_s = {1'b0, num_rounds, 1'b0} + 6'd2;
    if (num_rounds <= 4'd3) begin
      n_s = 7'd24;
    end else begin
      n_s = ({3'b000, num_rounds} * 7'd6) + 7'd6;
    end
  end

  // One mixing step: A' from S[i], then B' rotated by the low nibble of A'+B.
  always_comb begin
    i_inc_s  = {1'b0, i_r} + 6'd1;
    sum_a_s  = s_mem[i_r] + a_r + b_r;
    a_next_s = rotl16(sum_a_s, 4'd3);
    ab_s     = a_next_s + b_r;
    b_next_s = rotl16(l_mem[j_r] + ab_s, ab_s[3:0]);
  end

  // Table storage writes: key latch on start, constant fill in INIT, mix in MIX.
  // Contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == ST_IDLE) && start) begin
      for (int jj = 0; jj < 8; jj++) begin
        l_mem[jj] <= key[16*jj +: 16];
      end
    end else if (!rst && (state_r == ST_INIT)) begin
      s_mem[i_r] <= acc_r;
    end else if (!rst && (state_r == ST_MIX)) begin
      s_mem[i_r] <= a_next_s;
      l_mem[j_r] <= b_next_s;
    end
  end

  // Control FSM with registered status outputs and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b0;
      rd_data_r <= 16'h0000;
      acc_r     <= 16'h0000;
      a_r       <= 16'h0000;
      b_r       <= 16'h0000;
      i_r       <= 5'd0;
      j_r       <= 3'd0;
      count_r   <= 7'd0;
      t_r       <= 6'd0;
      n_r       <= 7'd0;
    end else begin
      // A read issued in the done cycle still returns zero: the table only
      // becomes readable once the FSM is back in IDLE.
      if (ready_r && !done_r && ({1'b0, rd_addr} < t_r)) begin
        rd_data_r <= s_mem[rd_addr];
      end else begin
        rd_data_r <= 16'h0000;
      end

      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            t_r     <= t_s;
            n_r     <= n_s;
            acc_r   <= P_CONST;
            i_r     <= 5'd0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_INIT;
          end
        end

        ST_INIT: begin
          acc_r <= acc_r + Q_CONST;
          if ({1'b0, i_r} == (t_r - 6'd1)) begin
            a_r     <= 16'h0000;
            b_r     <= 16'h0000;
            i_r     <= 5'd0;
            j_r     <= 3'd0;
            count_r <= 7'd0;
            state_r <= ST_MIX;
          end else begin
            i_r <= i_r + 5'd1;
          end
        end

        ST_MIX: begin
          a_r     <= a_next_s;
          b_r     <= b_next_s;
          i_r     <= (i_inc_s == t_r) ? 5'd0 : i_inc_s[4:0];
          j_r     <= j_r + 3'd1;
          count_r <= count_r + 7'd1;
          if (count_r == (n_r - 7'd1)) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            ready_r <= 1'b1;
            state_r <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Start is ignored here; the next IDLE cycle may accept one.
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          ready_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign ready   = ready_r;
  assign rd_data = rd_data_r;

endmodule
